router_read_agent: RTL
======================

# router_read_agent

Destination-side read agent for one router output port. It watches the port FIFO's `vld_out` and waits a programmable delay. It then drains one complete packet (header, payload, parity) through the `read_enb` / `data_out` handshake and checks the packet's parity and address. It also streams payload bytes to the client and reports a per-packet status. One instance sits behind each of the three router output FIFOs.

## Interface
- `RD_DELAY`, default 4: cycles `vld_out` must be high in IDLE before the first read. Legal range 0..25, which keeps the agent inside the synchroniser's 30-cycle soft-reset window.
- `PORT_ID`, default 2'd0: expected header address for this port.
- `clk` input 1: the single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `vld_out` input 1: FIFO non-empty.
- `data_out` input 8: FIFO read data, valid the cycle after `read_enb` is high.
- `soft_reset` input 1: the synchroniser's timeout flush for this port.
- `read_enb` output 1: FIFO read request.
- `byte_data` output 8: payload byte to the client.
- `byte_valid` output 1: `byte_data` is valid this cycle.
- `pkt_done` output 1: one-cycle pulse when a packet completes.
- `pkt_len` output 6: payload length from the header; held until the next header.
- `parity_err` output 1: valid with `pkt_done`; held until the next packet starts.
- `addr_err` output 1: header address differed from `PORT_ID`; same timing as `parity_err`.
- `abort` output 1: one-cycle pulse when a packet is abandoned because of `soft_reset`.

## Operation
- Packet format:
  - Header: bits [7:2] = payload length L (0..63), bits [1:0] = address.
  - L payload bytes follow.
  - Final byte: parity, the XOR of the header and all payload bytes.
- FSM states: IDLE, DELAY, HDR_RD, HDR_WAIT, BODY, CHECK.
- IDLE: when `vld_out` is 1, go to DELAY and clear the delay counter. With `RD_DELAY`=0, go straight to HDR_RD.
- DELAY: increment the counter each cycle. When it reaches `RD_DELAY`-1, go to HDR_RD. If `vld_out` drops, return to IDLE.
- HDR_RD:
  - Drive `read_enb` = `vld_out`.
  - On the cycle `read_enb` is high, go to HDR_WAIT.
- HDR_WAIT: sample `data_out`, latch `pkt_len` and the address, and initialise the running parity to the header. Set the remaining-read count to L+1 and the remaining-receive count to L+1. Go to BODY.
- BODY:
  - `read_enb` = `vld_out` AND (remaining reads != 0). Each asserted `read_enb` decrements the remaining reads.
  - A registered flag `rd_q` (= last cycle's `read_enb`) marks valid `data_out`. On each `rd_q` cycle, decrement the remaining receives and XOR the byte into the running parity.
  - A received byte that is not the last one is driven on `byte_data` with `byte_valid`=1 the following cycle.
  - When the last byte (parity) is received, go to CHECK.
- CHECK (1 cycle):
  - Pulse `pkt_done`.
  - `parity_err` = (running parity including the parity byte) != 0.
  - `addr_err` = (address != `PORT_ID`).
  - Go to IDLE.
- `vld_out` low in the middle of a packet (FIFO momentarily empty): `read_enb` is held low. There is no error and no timeout inside the agent.
- `soft_reset`=1 in any state other than IDLE or CHECK:
  - Go to IDLE on the next edge and pulse `abort`.
  - Clear the counters and `rd_q`.
  - No `pkt_done` is generated and no further `byte_valid` for that packet.
  - In IDLE, `soft_reset` is ignored.
- `soft_reset` in the same cycle as the final receive: `soft_reset` wins. The block aborts and does not go to CHECK.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- `read_enb` is combinational from state and `vld_out`; it is never high outside HDR_RD and BODY.
- Read latency: `read_enb` in cycle t means `data_out` is sampled in cycle t+1. A payload byte sampled in cycle t+1 appears on `byte_data`/`byte_valid` in cycle t+2.
- Reads per packet: exactly L+2. With the FIFO never empty, the first read occurs `RD_DELAY` cycles after `vld_out` rises.
- Header turnaround: one bubble cycle between the header read and the first body read (the HDR_WAIT state).
- L=0: the body is the parity byte only; there are no `byte_valid` pulses.
- `pkt_done` occurs one cycle after the parity byte is sampled. IDLE follows, and the next packet can start on the following cycle.
- `pkt_len` is a 6-bit field. The receive counter is 7 bits wide so that L+1=64 is representable.

## Test plan
- **Nominal packet.** Stimulus: `RD_DELAY`=4; header 8'h0C (L=3, addr 0); payload 11,22,33; correct parity; FIFO always valid. Required response: the first `read_enb` comes 4 cycles after `vld_out`; 5 reads total; `byte_valid` three times with 11,22,33; `pkt_done` with `parity_err`=0, `addr_err`=0, `pkt_len`=3.
- **Bad parity.** Stimulus: same packet with parity byte XOR 8'h01. Required response: `pkt_done` with `parity_err`=1; payload still delivered.
- **L=0, wrong address.** Stimulus: header 8'h01 (L=0, addr 1) with `PORT_ID`=0; parity 8'h01. Required response: 2 reads, no `byte_valid`, `pkt_done` with `addr_err`=1 and `parity_err`=0.
- **FIFO gap.** Stimulus: L=5 packet; `vld_out` driven low for 3 cycles after the second payload read. Required response: `read_enb` is low during the gap, then reads resume; exactly 7 reads total; correct status.
- **Soft reset mid-body.** Stimulus: L=10 packet; assert `soft_reset` after the fourth payload byte. Required response: `abort` pulses; no `pkt_done`; FSM returns to IDLE; the next clean packet is received correctly.
- **Reset mid-packet.** Stimulus: assert `reset` asynchronously in BODY. Required response: all outputs go to 0 immediately; the FSM restarts from IDLE after `reset` is released.

Source files
------------

// File: rtl/router_read_agent.sv
// router_read_agent
//
// Destination-side read agent for one router output FIFO. Once vld_out has
// been high for RD_DELAY cycles it drains one packet (header, L payload
// bytes, parity). Payload bytes are forwarded to the client, and parity and
// address are checked when the packet ends.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   vld_out           FIFO non-empty
//   data_out[7:0]     FIFO read data, valid the cycle after read_enb
//   soft_reset        synchroniser timeout flush; abandons the current packet
//   read_enb          FIFO read request (combinational)
//   byte_data[7:0]    payload byte to the client
//   byte_valid        byte_data valid this cycle
//   pkt_done          one-cycle pulse at packet completion
//   pkt_len[5:0]      payload length of the latest header
//   parity_err        parity check result, valid with pkt_done
//   addr_err          header address != PORT_ID, valid with pkt_done
//   abort             one-cycle pulse when a packet is abandoned
module router_read_agent #(
    parameter int         RD_DELAY = 4,
    parameter logic [1:0] PORT_ID  = 2'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       soft_reset,
    output logic       read_enb,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic       abort
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        HDR_RD,
        HDR_WAIT,
        BODY,
        CHECK
    } state_t;

    // The IDLE cycle in which vld_out is first seen counts as the first
    // cycle of the delay. A delay of 0 or 1 therefore skips DELAY entirely,
    // and larger delays leave DELAY when the incremented count reaches
    // RD_DELAY-1.
    localparam bit       SKIP_DELAY = (RD_DELAY <= 1);
    localparam logic [4:0] DLY_LAST = 5'(RD_DELAY - 1);

    state_t      state_q, state_d;
    logic [4:0]  dly_cnt_q, dly_cnt_d;
    logic [6:0]  rd_rem_q, rd_rem_d;
    logic [6:0]  rx_rem_q, rx_rem_d;
    logic        rd_q, rd_d;
    logic [7:0]  parity_q, parity_d;
    logic [1:0]  addr_q, addr_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        pkt_done_q, pkt_done_d;
    logic [5:0]  pkt_len_q, pkt_len_d;
    logic        parity_err_q, parity_err_d;
    logic        addr_err_q, addr_err_d;
    logic        abort_q, abort_d;

    logic        abort_now;
    logic        rx_last;
    logic [4:0]  dly_inc;

    // soft_reset only abandons a packet that is actually in progress.
    assign abort_now = soft_reset && (state_q != IDLE) && (state_q != CHECK);
    // The final byte received is the parity byte.
    assign rx_last   = (state_q == BODY) && rd_q && (rx_rem_q == 7'd1);
    assign dly_inc   = dly_cnt_q + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dly_cnt_q    <= '0;
            rd_rem_q     <= '0;
            rx_rem_q     <= '0;
            rd_q         <= 1'b0;
            parity_q     <= '0;
            addr_q       <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_len_q    <= '0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_cnt_q    <= dly_cnt_d;
            rd_rem_q     <= rd_rem_d;
            rx_rem_q     <= rx_rem_d;
            rd_q         <= rd_d;
            parity_q     <= parity_d;
            addr_q       <= addr_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
            pkt_len_q    <= pkt_len_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_now) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (vld_out) state_d = SKIP_DELAY ? HDR_RD : DELAY;
                DELAY: begin
                    if (!vld_out)                 state_d = IDLE;
                    else if (dly_inc == DLY_LAST) state_d = HDR_RD;
                end
                HDR_RD:   if (read_enb) state_d = HDR_WAIT;
                HDR_WAIT: state_d = BODY;
                BODY:     if (rx_last) state_d = CHECK;
                CHECK:    state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // read_enb depends only on state and vld_out. In BODY it also stops once
    // all L+1 body reads have been issued, even while the last bytes are
    // still in flight.
    always_comb begin
        read_enb = 1'b0;
        case (state_q)
            HDR_RD:  read_enb = vld_out;
            BODY:    read_enb = vld_out && (rd_rem_q != 7'd0);
            default: read_enb = 1'b0;
        endcase
    end

    // Datapath: counters, running parity, and the registered client/status
    // outputs. Status fields hold their value between packets.
    always_comb begin
        dly_cnt_d    = dly_cnt_q;
        rd_rem_d     = rd_rem_q;
        rx_rem_d     = rx_rem_q;
        rd_d         = read_enb;
        parity_d     = parity_q;
        addr_d       = addr_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_len_d    = pkt_len_q;
        parity_err_d = parity_err_q;
        addr_err_d   = addr_err_q;
        abort_d      = 1'b0;

        if (abort_now) begin
            dly_cnt_d = '0;
            rd_rem_d  = '0;
            rx_rem_d  = '0;
            rd_d      = 1'b0;
            abort_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE:  dly_cnt_d = '0;
                DELAY: dly_cnt_d = dly_inc;
                HDR_WAIT: begin
                    pkt_len_d    = data_out[7:2];
                    addr_d       = data_out[1:0];
                    parity_d     = data_out;
                    rd_rem_d     = {1'b0, data_out[7:2]} + 7'd1;
                    rx_rem_d     = {1'b0, data_out[7:2]} + 7'd1;
                    parity_err_d = 1'b0;
                    addr_err_d   = 1'b0;
                end
                BODY: begin
                    if (read_enb) rd_rem_d = rd_rem_q - 7'd1;
                    if (rd_q) begin
                        rx_rem_d = rx_rem_q - 7'd1;
                        parity_d = parity_q ^ data_out;
                        if (rx_last) begin
                            parity_err_d = ((parity_q ^ data_out) != 8'd0);
                            addr_err_d   = (addr_q != PORT_ID);
                            pkt_done_d   = 1'b1;
                        end else begin
                            byte_data_d  = data_out;
                            byte_valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_len    = pkt_len_q;
    assign parity_err = parity_err_q;
    assign addr_err   = addr_err_q;
    assign abort      = abort_q;

endmodule
